clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
Parametrised N-channel programmable clock/pulse divider. It generalises the fixed 1250-cycle, 50 %-duty divider in vidor_sys.
Each channel runs an independent counter with its own runtime-programmable period and high-time, held in shadow registers so updates never glitch. Sits in vidor_sys between the system clock domain and peripheral timing logic (PWM, sampling strobes, LED blink).

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
CNT_W, 32, width of counters and period/high registers
DEF_PERIOD, 1250, reset value of every channel's period (cycles per output period)
DEF_HIGH, 625, reset value of every channel's high-time (cycles output is 1 per period)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  CHANNELS  per-channel run enable, level-sensitive
sync  in  1  one-cycle strobe: restart all enabled channels at count 0
cfg_wr  in  1  configuration write strobe
cfg_chan  in  clog2(CHANNELS) (min 1)  target channel of write
cfg_sel  in  1  0 = period register, 1 = high-time register
cfg_data  in  CNT_W  write data
cfg_pending  out  CHANNELS  1 = channel has shadow value not yet applied
out_clk  out  CHANNELS  divided clock / pulse output, registered

Behaviour:
- Reset (reset=0, async): cnt=0, active and shadow period=DEF_PERIOD, high=DEF_HIGH, out_clk=0, cfg_pending=0, tick=0.
- Per channel: counter cnt runs 0..P-1, where P = active period. Output period is exactly P cycles. out_clk=1 while cnt<H (H = active high-time), else 0.
- P clamp: effective P = max(P, 2); values 0/1 written are stored but treated as 2.
- H=0: out_clk constant 0. H>=P: out_clk constant 1.
- out_clk is a register holding the value for the current cnt; no combinational path from inputs.
- Enable rising: on the first edge with enable=1, cnt=0 and out_clk=(H>0). enable=0: cnt held 0, out_clk=0 on next edge.
- Write: cfg_wr with cfg_chan>=CHANNELS is ignored. Otherwise cfg_data goes to the selected shadow register and cfg_pending[ch] is set on the next edge.
- Apply: shadow copies to active (both registers), and pending clears, at any of:
  - wrap edge (cnt==P-1, enable=1)
  - sync edge
  - any edge while enable=0
- Write coincident with wrap/apply: the written value is included in that apply. Pending ends 0.
- Arithmetic: counter increment modulo 2^CNT_W. Compares are unsigned. No overflow, since cnt<P.
- sync: all enabled channels: cnt=0, apply shadows, out_clk=(H_new>0). Disabled channels unaffected apart from shadow apply. sync has priority over wrap and normal increment.
- Reset asserted mid-period: immediate return to reset values. Programmed values are lost.

Optional Feature:
Macro CLKDIV_TICK_EN.
- Defined: adds output port tick [CHANNELS]. tick[i]=1 for exactly one cycle coincident with cnt==0 of every period, including the first cycle after enable rise or sync. Registered; reset 0; 0 while disabled.
- Undefined: port absent, no tick logic.

Test Plan:
- Defaults, enable[0]=1 after reset release → out_clk[0] high 625 cycles, low 625, period 1250, repeating. Other channels stay 0.
- Ch1 write period=10, high=3 mid-period of default → cfg_pending[1]=1 until current 1250-cycle period ends. Then 3 high / 7 low, pending=0.
- Ch2 high=0 → out constant 0. high=20 with period=10 → constant 1. period=1, high=1 → 1 high / 1 low (clamp to 2).
- Ch0 period=8, ch1 period=12 running, sync pulse → both out_clk high on next cycle with cnt=0. Disabled ch3 stays 0.
- Write coincident with wrap edge (ch0 period=4 → write 6 at cnt==3) → next period already 6 cycles, pending stays 0. reset=0 mid-high → out_clk=0 immediately, defaults restored.
- CLKDIV_TICK_EN, ch0 period=5 → tick[0] one cycle every 5 cycles, aligned with out_clk rising. No tick while enable=0.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   N-channel programmable clock / pulse divider. Each channel owns a free
//   running counter cnt that counts 0..P-1, where P is the channel's active
//   period. The channel's output is 1 while cnt < H, where H is the active
//   high-time. Both P and H sit behind shadow registers. A new value only
//   moves into the active registers at a period boundary (wrap or sync), or
//   at any edge while the channel is disabled. A running output therefore
//   never sees a truncated or stretched period.
//
//   Optional feature macro: CLKDIV_TICK_EN
//     When defined, the design has an extra per-channel output `tick`. It
//     pulses for one cycle together with cnt==0 of every period.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   [CHANNELS] per-channel run enable (level)
//   sync        in   one-cycle strobe, restarts all enabled channels
//   cfg_wr      in   configuration write strobe
//   cfg_chan    in   [CH_W] target channel; values >= CHANNELS are ignored
//   cfg_sel     in   0 = period shadow, 1 = high-time shadow
//   cfg_data    in   [CNT_W] write data
//   cfg_pending out  [CHANNELS] shadow holds a value not yet applied
//   out_clk     out  [CHANNELS] divided output, registered
//   tick        out  [CHANNELS] period-start pulse (CLKDIV_TICK_EN only)
module clock_divider_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 1250,
  parameter int DEF_HIGH   = 625,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic                cfg_sel,
  input  logic [CNT_W-1:0]    cfg_data,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] out_clk
`ifdef CLKDIV_TICK_EN
  ,
  output logic [CHANNELS-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_W-1:0] cnt, act_p, act_h, sh_p, sh_h;
    logic [CNT_W-1:0] sh_p_nx, sh_h_nx, p_eff, cnt_nx, h_use;
    logic             run, pend_q, out_q;
    logic             wr_hit, wrap, apply, restart, out_nx;

    always_comb begin
      // NOTE: every signal gets a default before any branch. A path that
      // leaves a signal unassigned would infer a latch.
      sh_p_nx = sh_p;
      sh_h_nx = sh_h;
      cnt_nx  = '0;
      out_nx  = 1'b0;
      // Writes to channel numbers beyond CHANNELS never match any channel.
      wr_hit  = cfg_wr && (32'(cfg_chan) == i);
      if (wr_hit) begin
        if (cfg_sel) sh_h_nx = cfg_data;
        else         sh_p_nx = cfg_data;
      end
      // Stored periods of 0 or 1 run as 2 so that a wrap always exists.
      p_eff   = (act_p < TWO) ? TWO : act_p;
      wrap    = enable[i] && run && (cnt == p_eff - ONE);
      // The shadow values seen here already include a write on this same
      // edge, so a write that lands on an apply edge is taken at once.
      apply   = sync || !enable[i] || wrap;
      restart = enable[i] && (sync || !run || wrap);
      h_use   = apply ? sh_h_nx : act_h;
      if (!enable[i]) begin
        cnt_nx = '0;
        out_nx = 1'b0;
      end else if (restart) begin
        cnt_nx = '0;
        out_nx = (h_use != '0);
      end else begin
        cnt_nx = cnt + ONE;
        out_nx = (cnt_nx < act_h);
      end
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers, including the shadow and active configuration, take known
    // reset values, so a channel restarts from its defaults after reset.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        act_p  <= RST_P;
        act_h  <= RST_H;
        sh_p   <= RST_P;
        sh_h   <= RST_H;
        run    <= 1'b0;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        cnt    <= cnt_nx;
        out_q  <= out_nx;
        run    <= enable[i];
        sh_p   <= sh_p_nx;
        sh_h   <= sh_h_nx;
        pend_q <= !apply && (pend_q || wr_hit);
        if (apply) begin
          act_p <= sh_p_nx;
          act_h <= sh_h_nx;
        end
      end
    end

    assign out_clk[i]     = out_q;
    assign cfg_pending[i] = pend_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) tick_q <= 1'b0;
      else        tick_q <= restart;
    end
    assign tick[i] = tick_q;
`endif
  end

endmodule
